// File: rtl/ehl_reorder.sv
// Reordering buffer: applies a bit/byte permutation at acceptance and holds up to two
// transformed words in a FIFO with registered ready/valid handshakes.
module ehl_reorder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    localparam int unsigned NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] r_mem [0:1];
    logic [1:0]       r_count;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_dout;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;
    logic             w_wr_ptr_nxt;
    logic             w_rd_ptr_nxt;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_head_nxt;
    logic [WIDTH-1:0] w_dout_nxt;

    function automatic logic [WIDTH-1:0] f_reorder(input logic [1:0] m,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            2'd1: begin
                for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
            end
            2'd2: begin
                for (int k = 0; k < NBYTES; k++)
                    for (int j = 0; j < 8; j++) r[8*k+j] = d[8*(NBYTES-1-k)+j];
            end
            2'd3: begin
                for (int k = 0; k < NBYTES; k++)
                    for (int j = 0; j < 8; j++) r[8*k+j] = d[8*k+7-j];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        w_word       = f_reorder(mode, din);
        w_push       = in_valid && r_in_ready;
        w_pop        = (r_count != 2'd0) && out_ready;
        w_count_nxt  = r_count + {1'b0, w_push} - {1'b0, w_pop};
        w_wr_ptr_nxt = r_wr_ptr ^ w_push;
        w_rd_ptr_nxt = r_rd_ptr ^ w_pop;
        // The next head is either the word being written this cycle or an already stored one.
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_word;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
        w_dout_nxt = (w_count_nxt != 2'd0) ? w_head_nxt : r_dout;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_ready <= 1'b0;
            r_dout     <= '0;
        end else begin
            if (w_push) r_mem[r_wr_ptr] <= w_word;
            r_count    <= w_count_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
            r_dout     <= w_dout_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign busy      = (r_count != 2'd0);
    assign dout      = r_dout;

endmodule

// File: tb/tb_ehl_reorder.sv
// Self-checking bench for ehl_reorder: vector table, scoreboard monitor and
// hand-written back-pressure, mode-change and reset sequences.
module tb_ehl_reorder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;
    logic        busy;

    int n_checks;
    int n_fails;
    int n_delivered;
    logic [31:0] sb_q[$];

    ehl_reorder #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference built from streaming operators.
    function automatic logic [31:0] ref_model(input logic [1:0] m, input logic [31:0] d);
        logic [31:0] t;
        case (m)
            2'd1: t = {<<{d}};
            2'd2: t = {<<8{d}};
            2'd3: begin
                t = {<<{d}};
                t = {<<8{t}};
            end
            default: t = d;
        endcase
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change at posedge+1, so at negedge they hold what the next edge samples.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", dout, 32'hxxxx_xxxx);
                end else begin
                    check("scoreboard_dout", dout, sb_q.pop_front());
                end
                n_delivered++;
            end
            if (in_valid && in_ready) sb_q.push_back(ref_model(mode, din));
        end
    end

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];
    int   base;
    int   guard;

    initial begin
        vecs[0] = '{2'd1, 32'h0000_0001, 32'h8000_0000};
        vecs[1] = '{2'd2, 32'h1122_3344, 32'h4433_2211};
        vecs[2] = '{2'd3, 32'h0102_0380, 32'h8040_C001};
        vecs[3] = '{2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{2'd1, 32'h1234_5678, 32'h1E6A_2C48};
        vecs[5] = '{2'd2, 32'hA5B6_C7D8, 32'hD8C7_B6A5};
        vecs[6] = '{2'd3, 32'h1234_5678, 32'h482C_6A1E};

        n_checks = 0; n_fails = 0; n_delivered = 0;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0; mode = '0;
        repeat (2) step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_dout", dout, 32'd0);
        reset_n = 1'b1;
        #2;
        check("in_ready_before_edge", {31'b0, in_ready}, 32'd0);
        step();
        check("in_ready_after_release", {31'b0, in_ready}, 32'd1);

        // Single-word vectors: one-cycle latency, then drained.
        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode; din = vecs[i].din;
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            check("vec_out_valid", {31'b0, out_valid}, 32'd1);
            check("vec_dout", dout, vecs[i].exp);
            in_valid = 1'b0;
            step();
            check("vec_drained", {31'b0, out_valid}, 32'd0);
        end
        check("hold_last_dout", dout, vecs[6].exp);

        // Back-pressure: A, B fill the FIFO; C is refused.
        out_ready = 1'b0; mode = 2'd0;
        in_valid = 1'b1; din = 32'hA; step();
        din = 32'hB; step();
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_busy", {31'b0, busy}, 32'd1);
        din = 32'hC; out_ready = 1'b1;
        step();
        check("full_refuse_pop_a", dout, 32'hB);
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        check("stall_dout_b", dout, 32'hB);
        out_ready = 1'b1;
        step();
        check("bp_empty", {31'b0, out_valid}, 32'd0);
        check("bp_hold_b", dout, 32'hB);

        // Mode change after acceptance must not affect the stored word.
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'd1; din = 32'h0000_00FF;
        step();
        in_valid = 1'b0; mode = 2'd0;
        repeat (3) step();
        check("mode_change_dout", dout, 32'hFF00_0000);
        out_ready = 1'b1;
        step();
        check("mode_change_drained", {31'b0, out_valid}, 32'd0);

        // Streaming: one word per cycle, count never reaches 2.
        base = n_delivered;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            mode = 2'($urandom_range(0, 3));
            din = $urandom;
            step();
            check("stream_in_ready", {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        guard = 0;
        do begin
            step();
            guard++;
        end while (out_valid && guard < 10);
        check("stream_count", n_delivered - base, 32'd100);

        // Asynchronous reset with a full FIFO.
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0;
        din = 32'h1111_1111; step();
        din = 32'h2222_2222; step();
        in_valid = 1'b0;
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_in_ready", {31'b0, in_ready}, 32'd0);
        check("async_busy", {31'b0, busy}, 32'd0);
        check("async_dout", dout, 32'd0);
        step();
        #3;
        reset_n = 1'b1;
        step();
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            check("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
        end
        check("post_rst_dout", dout, 32'd0);
        in_valid = 1'b1; mode = 2'd2; din = 32'h1122_3344;
        step();
        check("post_rst_word", dout, 32'h4433_2211);
        in_valid = 1'b0;
        step();
        check("final_empty", {31'b0, out_valid}, 32'd0);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ehl_reorder.md
EHL_REORDER -- requirements
Module: ehl_reorder

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n  input  1: asynchronous, active-low reset.
REQ-004 Port in_valid  input  1: the source presents a word.
REQ-005 Port in_ready  output  1: the block can accept a word this cycle.
REQ-006 Port din  input  WIDTH: input data word.
REQ-007 Port mode  input  2: reorder mode, sampled together with din.
REQ-008 Port out_valid  output  1: dout holds a valid word.
REQ-009 Port out_ready  input  1: the sink accepts dout this cycle.
REQ-010 Port dout  output  WIDTH: reordered data word.
REQ-011 Port busy  output  1: at least one word is held inside the block.

Function
REQ-012 A word SHALL be accepted on a rising edge of clk where in_valid=1 and in_ready=1.
REQ-013 A word SHALL be delivered on a rising edge of clk where out_valid=1 and out_ready=1.
REQ-014 mode SHALL be applied to din at acceptance, and the transformed word SHALL be stored; later changes to mode SHALL NOT affect stored words.
REQ-015 mode 0 (pass): dout[i] = din[i].
REQ-016 mode 1 (full bit reverse): dout[i] = din[WIDTH-1-i] for all i.
REQ-017 mode 2 (byte swap): byte k of the output SHALL equal byte WIDTH/8-1-k of the input; bit order within each byte is kept.
REQ-018 mode 3 (bit reverse per byte): bit j of output byte k SHALL equal bit 7-j of input byte k.
REQ-019 Storage SHALL be a 2-entry FIFO holding transformed words, tracked by an occupancy count of 0..2.
REQ-020 in_ready SHALL be 1 when the count is less than 2; it SHALL be driven from registers only and SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL equal (count != 0), and dout SHALL present the oldest entry.
REQ-022 busy SHALL equal (count != 0).
REQ-023 Latency: a word accepted at edge N SHALL appear on dout with out_valid=1 right after edge N when the FIFO was empty; minimum latency is 1 cycle.
REQ-024 Throughput: with in_valid=1 and out_ready=1 held, the block SHALL accept and deliver one word per cycle, and the count SHALL stay constant.
REQ-025 Simultaneous accept and deliver SHALL leave the count unchanged and keep FIFO order.
REQ-026 Full (count=2): in_ready=0, and no word SHALL be accepted even if out_ready=1 in the same cycle.
REQ-027 Empty (count=0): out_valid=0; dout SHALL hold its last value and SHALL NOT be X after the first reset.
REQ-028 Read and write pointers SHALL be 1 bit wide and wrap from 1 to 0.
REQ-029 Words SHALL never be dropped, duplicated or reordered.
REQ-030 While out_valid=1 and out_ready=0, dout SHALL stay stable.

Reset
REQ-031 On reset_n=0, immediately and independently of clk: count=0, pointers=0, in_ready=0, out_valid=0, busy=0, dout=0, and all FIFO entries=0.
REQ-032 After reset_n deasserts, in_ready SHALL rise on the first clk rising edge.
REQ-033 Reset mid-operation SHALL discard all stored words; no stored word SHALL appear after reset.

Verification
REQ-034 WIDTH=32, mode=1, din=32'h0000_0001, out_ready=1 -> dout=32'h8000_0000, out_valid=1 one cycle after acceptance.
REQ-035 WIDTH=32, mode=2, din=32'h1122_3344 -> dout=32'h4433_2211; mode=3, din=32'h0102_0380 -> dout=32'h8040_C001; mode=0 passes unchanged.
REQ-036 Back-pressure: out_ready=0, push 32'hA, 32'hB -> in_ready=0 after the 2nd push and a 3rd word is not accepted; raise out_ready -> A then B delivered in order.
REQ-037 Streaming: in_valid=out_ready=1 for 100 cycles with random mode and data -> 100 words out, each matching a reference model, count never above 1.
REQ-038 Mode change: accept din=32'h0000_00FF with mode=1, then switch mode to 0 while the word is stalled -> dout remains 32'hFF00_0000.
REQ-039 Reset: assert reset_n=0 asynchronously with count=2 -> out_valid, in_ready, busy and dout go to 0 without a clock edge; after release, empty FIFO and no stale data.
